// File: rtl/us_pkg.sv
// Shared types and default timing for the ultrasonic scan scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: scan FSM state encoding, channel-index width helper, default timing at 50 MHz.
package us_pkg;

    // Default timing constants, 50 MHz core clock
    localparam int START_CYC_DEF   = 2;        // trigger level width
    localparam int TIMEOUT_CYC_DEF = 1500000;  // 30 ms echo window
    localparam int GUARD_CYC_DEF   = 3000000;  // 60 ms acoustic settle gap

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        GUARD     = 3'd4
    } us_state_e;

    // Width of a channel index; never below 1 bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/us_rr_pick.sv
// Round-robin channel picker: first enabled channel strictly after the last one served.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   mask_i  channels participating in the scan
//   last_i  channel served most recently
//   next_o  channel to serve next (equals last_i when it is the only one set)
//   any_o   at least one channel is enabled
module us_rr_pick
    import us_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] mask_i,
    input  logic [CH_W-1:0] last_i,
    output logic [CH_W-1:0] next_o,
    output logic            any_o
);

    always_comb begin
        next_o = last_i;
        any_o  = |mask_i;
        // Wrap candidate: lowest set bit overall. Iterating downwards lets the
        // lowest index win; this also covers "only last_i set" -> last_i again.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                next_o = CH_W'(i);
            end
        end
        // Preferred candidate: lowest set bit above last_i, overrides the wrap.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (CH_W'(i) > last_i)) begin
                next_o = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/us_scan_scheduler.sv
// Time-multiplexes N_CH ultrasonic rangers so only one pings at a time; latches near/timeout per channel.
// Latency: first meas_start 2 clk after enable rises in IDLE; result_valid 1 clk after done/timeout.
// Backpressure: none; units answer with a done pulse, a silent unit is cut off after TIMEOUT_CYC.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   enable_i          level, scanning allowed
//   ch_mask_i         channels participating (sampled once per pick)
//   meas_done_i       1-cycle done pulse per unit
//   meas_near_i       near result per unit, valid with its done pulse
//   meas_start_o      one-hot trigger level, START_CYC cycles
//   active_ch_o       channel currently served
//   busy_o            FSM not idle
//   near_flags_o      last valid near result per channel
//   tmo_flags_o       last attempt on channel timed out
//   result_valid_o    1-cycle pulse when a channel finishes
module us_scan_scheduler
    import us_pkg::*;
#(
    parameter int  N_CH        = 4,
    parameter int  START_CYC   = START_CYC_DEF,
    parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int  GUARD_CYC   = GUARD_CYC_DEF,
    localparam int CH_W        = ch_w(N_CH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable_i,
    input  logic [N_CH-1:0] ch_mask_i,
    input  logic [N_CH-1:0] meas_done_i,
    input  logic [N_CH-1:0] meas_near_i,
    output logic [N_CH-1:0] meas_start_o,
    output logic [CH_W-1:0] active_ch_o,
    output logic            busy_o,
    output logic [N_CH-1:0] near_flags_o,
    output logic [N_CH-1:0] tmo_flags_o,
    output logic            result_valid_o
);

    // One counter shared by START, WAIT_DONE and GUARD; START_CYC is folded in
    // so an unusually long trigger width can never overflow it.
    localparam int CNT_W = $clog2(max2(max2(TIMEOUT_CYC, GUARD_CYC), START_CYC) + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CH_W-1:0]  LAST_RST   = CH_W'(N_CH - 1);

    us_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [N_CH-1:0]   near_q, near_d;
    logic [N_CH-1:0]   tmo_q, tmo_d;
    logic              rv_q, rv_d;

    logic [CH_W-1:0]   pick_ch;
    logic              pick_any;
    logic              act_done;
    logic              scan_ok;

    us_rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .mask_i (ch_mask_i),
        .last_i (last_ch_q),
        .next_o (pick_ch),
        .any_o  (pick_any)
    );

    // Only the served unit's done pulse counts; others are ignored everywhere.
    assign act_done = meas_done_i[active_ch_q];
    assign scan_ok  = enable_i && (|ch_mask_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        active_ch_d = active_ch_q;
        last_ch_d   = last_ch_q;
        near_d      = near_q;
        tmo_d       = tmo_q;
        rv_d        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (scan_ok) begin
                    state_d = SELECT;
                end
            end

            SELECT: begin
                cnt_d = '0;
                // Mask may have cleared in the one cycle since GUARD checked it.
                if (pick_any) begin
                    state_d     = START;
                    active_ch_d = pick_ch;
                    last_ch_d   = pick_ch;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                // Done pulses here are deliberately ignored: a real echo cannot
                // end before the trigger does.
                if (cnt_q == START_LAST) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end
            end

            WAIT_DONE: begin
                // Done is tested first so a done on the final cycle beats timeout.
                if (act_done) begin
                    near_d[active_ch_q] = meas_near_i[active_ch_q];
                    tmo_d[active_ch_q]  = 1'b0;
                    rv_d                = 1'b1;
                    state_d             = GUARD;
                    cnt_d               = '0;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d[active_ch_q] = 1'b1;
                    rv_d               = 1'b1;
                    state_d            = GUARD;
                    cnt_d              = '0;
                end
            end

            GUARD: begin
                // Enable/mask only take effect here, so a running measurement
                // and its guard gap always finish.
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = scan_ok ? SELECT : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            active_ch_q <= '0;
            last_ch_q   <= LAST_RST;  // first pick lands on ch0
            near_q      <= '0;
            tmo_q       <= '0;
            rv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_ch_q <= active_ch_d;
            last_ch_q   <= last_ch_d;
            near_q      <= near_d;
            tmo_q       <= tmo_d;
            rv_q        <= rv_d;
        end
    end

    // Trigger decoded from registered state so it drops on the same edge that
    // leaves START (including a reset edge).
    always_comb begin
        meas_start_o = '0;
        if (state_q == START) begin
            meas_start_o[active_ch_q] = 1'b1;
        end
    end

    assign active_ch_o    = active_ch_q;
    assign busy_o         = (state_q != IDLE);
    assign near_flags_o   = near_q;
    assign tmo_flags_o    = tmo_q;
    assign result_valid_o = rv_q;

endmodule

// File: tb/tb_us_scan_scheduler.sv
module tb_us_scan_scheduler;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam int GD = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] ch_mask = '0;
    logic [N-1:0] meas_done = '0;
    logic [N-1:0] meas_near = '0;
    logic [N-1:0] meas_start;
    logic [1:0]   active_ch;
    logic         busy;
    logic [N-1:0] near_flags;
    logic [N-1:0] tmo_flags;
    logic         result_valid;

    always #5 clk = ~clk;

    us_scan_scheduler #(
        .N_CH        (N),
        .START_CYC   (2),
        .TIMEOUT_CYC (TO),
        .GUARD_CYC   (GD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable_i       (enable),
        .ch_mask_i      (ch_mask),
        .meas_done_i    (meas_done),
        .meas_near_i    (meas_near),
        .meas_start_o   (meas_start),
        .active_ch_o    (active_ch),
        .busy_o         (busy),
        .near_flags_o   (near_flags),
        .tmo_flags_o    (tmo_flags),
        .result_valid_o (result_valid)
    );

    typedef struct {
        int ch;
        int near;
        int tmo;
        int lat;   // cycles from first start cycle to result_valid cycle
    } res_t;

    int   exp_start_q[$];
    res_t exp_res_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- ranging unit model ----------------
    logic [N-1:0] resp_en  = '0;
    logic [N-1:0] near_cfg = '0;
    int           resp_dly [N];
    logic         stray_en = 1'b0;   // fire a ch3 done while ch1 is served
    int           dly [N];
    logic [N-1:0] rsp_prev = '0;

    initial begin
        for (int c = 0; c < N; c++) begin
            dly[c]      = 0;
            resp_dly[c] = 5;
        end
        forever begin
            @(negedge clk);
            meas_done = '0;
            meas_near = N'($urandom);   // garbage outside done cycles
            if (!reset_n) begin
                for (int c = 0; c < N; c++) dly[c] = 0;
            end
            for (int c = 0; c < N; c++) begin
                if (dly[c] > 0) begin
                    dly[c]--;
                    if (dly[c] == 0) begin
                        meas_done[c] = 1'b1;
                        meas_near[c] = near_cfg[c];
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                if (meas_start[c] && !rsp_prev[c]) begin
                    if (resp_en[c]) dly[c] = resp_dly[c];
                    if (stray_en && c == 1) dly[3] = 4;
                end
            end
            rsp_prev = meas_start;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int           n_start = 0;
    int           start_cyc = 0;
    int           slen = 0;
    int           last_rv = 0;
    int           busy_fall_cyc = 0;
    logic         gap_armed = 1'b0;
    logic [N-1:0] exp_near = '0;
    logic [N-1:0] exp_tmo = '0;
    logic [N-1:0] mon_prev_start = '0;
    logic         prev_rv = 1'b0;
    logic         prev_busy = 1'b0;
    int           en_cyc = 0;
    int           first_req = 0;
    int           first_done = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_near  = '0;
                exp_tmo   = '0;
                gap_armed = 1'b0;
            end
            if (meas_start != '0 && mon_prev_start == '0) begin
                int ch;
                ch = 0;
                for (int c = 0; c < N; c++) if (meas_start[c]) ch = c;
                n_start++;
                start_cyc = cyc;
                slen = 0;
                chk("start_onehot", $countones(meas_start), 1);
                if (exp_start_q.size() == 0) chk("start_unexp", ch, -1);
                else chk("start_ch", ch, exp_start_q.pop_front());
                if (first_req != first_done) begin
                    chk("first_start_lat", cyc - en_cyc, 2);
                    first_done = first_req;
                end
                if (gap_armed) chk("guard_gap", cyc - last_rv, GD + 1);
                gap_armed = 1'b0;
            end
            if (meas_start != '0) slen++;
            if (meas_start == '0 && mon_prev_start != '0 && reset_n) chk("start_len", slen, 2);
            if (result_valid) begin
                chk("rv_pulse", int'(prev_rv), 0);
                if (exp_res_q.size() == 0) begin
                    chk("rv_unexp", int'(active_ch), -1);
                end else begin
                    res_t e;
                    e = exp_res_q.pop_front();
                    chk("rv_ch", int'(active_ch), e.ch);
                    chk("rv_lat", cyc - start_cyc, e.lat);
                    if (e.tmo != 0) begin
                        exp_tmo[e.ch] = 1'b1;
                    end else begin
                        exp_tmo[e.ch]  = 1'b0;
                        exp_near[e.ch] = e.near[0];
                    end
                    chk("rv_near_flags", int'(near_flags), int'(exp_near));
                    chk("rv_tmo_flags", int'(tmo_flags), int'(exp_tmo));
                end
                last_rv   = cyc;
                gap_armed = 1'b1;
            end
            if (prev_busy && !busy) begin
                busy_fall_cyc = cyc;
                gap_armed     = 1'b0;
            end
            mon_prev_start = meas_start;
            prev_rv        = result_valid;
            prev_busy      = busy;
        end
    end

    // ---------------- main sequence helpers ----------------
    task automatic push_meas(input int ch, input int near, input int tmo, input int lat);
        res_t r;
        r.ch = ch; r.near = near; r.tmo = tmo; r.lat = lat;
        exp_start_q.push_back(ch);
        exp_res_q.push_back(r);
    endtask

    task automatic go();
        en_cyc = cyc;
        first_req++;
        enable = 1'b1;
    endtask

    task automatic wait_starts(input string tag, input int target);
        int budget;
        budget = 3000;
        while (n_start < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, int'(n_start >= target), 1);
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 500;
        @(negedge clk);
        while (busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, int'(busy), 0);
    endtask

    task automatic chk_flags(input string tag, input int nf, input int tf);
        chk({tag, "_near"}, int'(near_flags), nf);
        chk({tag, "_tmo"}, int'(tmo_flags), tf);
        chk({tag, "_queue"}, exp_start_q.size() + exp_res_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int budget;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_start", int'(meas_start), 0);
        chk("rst_active", int'(active_ch), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_near", int'(near_flags), 0);
        chk("rst_tmo", int'(tmo_flags), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: full mask, all respond after 5 cycles, only ch0 reports near
        resp_en  = 4'b1111;
        near_cfg = 4'b0001;
        for (int c = 0; c < N; c++) resp_dly[c] = 5;
        push_meas(0, 1, 0, 6);
        push_meas(1, 0, 0, 6);
        push_meas(2, 0, 0, 6);
        push_meas(3, 0, 0, 6);
        push_meas(0, 1, 0, 6);
        ch_mask = 4'b1111;
        base = n_start;
        go();
        wait_starts("t1_starts", base + 5);
        enable = 1'b0;
        wait_idle("t1_idle");
        chk_flags("t1", 4'b0001, 4'b0000);

        // 2: mask 0101, ch2 silent -> timeout 20 cycles after START ends
        resp_en = 4'b0001;
        push_meas(2, 0, 1, 2 + TO);
        push_meas(0, 1, 0, 6);
        push_meas(2, 0, 1, 2 + TO);
        ch_mask = 4'b0101;
        base = n_start;
        go();
        wait_starts("t2_starts", base + 3);
        enable = 1'b0;
        wait_idle("t2_idle");
        chk_flags("t2", 4'b0001, 4'b0100);

        // 3: done exactly on timeout cycle wins; stray ch3 done ignored
        resp_en     = 4'b0011;
        resp_dly[0] = 2 + TO - 1;
        resp_dly[1] = 2 + TO - 1;
        near_cfg    = 4'b1010;
        stray_en    = 1'b1;
        push_meas(0, 0, 0, 2 + TO);
        push_meas(1, 1, 0, 2 + TO);
        ch_mask = 4'b0011;
        base = n_start;
        go();
        wait_starts("t3_starts", base + 2);
        enable = 1'b0;
        wait_idle("t3_idle");
        stray_en = 1'b0;
        chk_flags("t3", 4'b0010, 4'b0100);

        // 4: enable dropped during WAIT_DONE
        resp_en  = 4'b1111;
        near_cfg = 4'b1111;
        for (int c = 0; c < N; c++) resp_dly[c] = 8;
        push_meas(2, 1, 0, 9);
        ch_mask = 4'b1111;
        base = n_start;
        go();
        wait_starts("t4_starts", base + 1);
        repeat (3) @(negedge clk);
        chk("t4_in_wait_start", int'(meas_start), 0);
        chk("t4_in_wait_busy", int'(busy), 1);
        enable = 1'b0;
        wait_idle("t4_idle");
        chk("t4_guard_len", busy_fall_cyc - last_rv, GD);
        repeat (30) @(negedge clk);
        chk("t4_no_restart", n_start, base + 1);
        chk_flags("t4", 4'b0110, 4'b0000);

        // 5: empty mask keeps IDLE; single channel repeats
        ch_mask = 4'b0000;
        enable  = 1'b1;
        base = n_start;
        repeat (20) @(negedge clk);
        chk("t5_empty_busy", int'(busy), 0);
        chk("t5_empty_starts", n_start, base);
        resp_dly[3] = 5;
        push_meas(3, 1, 0, 6);
        push_meas(3, 1, 0, 6);
        push_meas(3, 1, 0, 6);
        ch_mask = 4'b1000;
        go();
        wait_starts("t5_starts", base + 3);
        enable = 1'b0;
        wait_idle("t5_idle");
        chk_flags("t5", 4'b1110, 4'b0000);

        // 6: reset during START
        for (int c = 0; c < N; c++) resp_dly[c] = 5;
        exp_start_q.push_back(0);
        ch_mask = 4'b1111;
        go();
        budget = 100;
        @(negedge clk);
        while (meas_start == '0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("t6_saw_start", int'(meas_start != '0), 1);
        reset_n = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        chk("t6_rst_start", int'(meas_start), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_near", int'(near_flags), 0);
        chk("t6_rst_tmo", int'(tmo_flags), 0);
        chk("t6_rst_active", int'(active_ch), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_meas(0, 1, 0, 6);
        base = n_start;
        go();
        wait_starts("t6_starts", base + 1);
        enable = 1'b0;
        wait_idle("t6_idle");
        chk_flags("t6", 4'b0001, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
